// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg: shared memory-interface state type and parameter defaults
// Rev 1.0
// ============================================================================
package cpu_pkg;

  localparam int c_ADDR_W_DEF      = 9;
  localparam int c_TIMEOUT_CYC_DEF = 16;
  localparam int c_DATA_W          = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  function automatic logic is_req(input mem_state_e s);
    return (s == RD_REQ) || (s == WR_REQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
// mem_watchdog: counts request cycles and flags expiry without mem_ack
// Rev 1.0
// ============================================================================
module mem_watchdog
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int                 c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);

  logic [c_CNT_W-1:0] cnt_q;

  // Ack on the final cycle still wins over expiry.
  assign expire_o = active_i & ~ack_i & (cnt_q == c_LAST);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (!active_i || ack_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// mem_interface: MAR/MDR RAM handshake FSM; MEM_TIMEOUT_EN adds an ack watchdog
// Rev 1.0
// ============================================================================
module mem_interface
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W_DEF,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       MDR_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              Ready,
  output logic              Busy,
  output logic              MemErr
);

  mem_state_e          state_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [c_DATA_W-1:0] mdr_q;
  logic                rd_q;
  logic                wr_q;
  logic                ready_q;
  logic                busy_q;
  logic                w_timeout;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_interface: TIMEOUT_CYC must be at least 1");
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .active_i (busy_q),
    .ack_i    (mem_ack),
    .expire_o (w_timeout)
  );

  assign MemErr = err_q;
`else
  assign w_timeout = 1'b0;
  assign MemErr    = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;

      // Address and data registers are frozen while an access is in flight.
      if (!is_req(state_q)) begin
        if (MARin) begin
          mar_q <= BusMuxOut[ADDR_W-1:0];
        end
        if (MDRin && !Read) begin
          mdr_q <= BusMuxOut;
        end
      end

      case (state_q)
        IDLE: begin
          if (Read) begin
            state_q <= RD_REQ;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end else if (Write) begin
            state_q <= WR_REQ;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end

        RD_REQ: begin
          if (mem_ack) begin
            mdr_q   <= mem_rdata;
            state_q <= DONE;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (w_timeout) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end
        end

        WR_REQ: begin
          if (mem_ack || w_timeout) begin
            state_q <= DONE;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            if (!mem_ack) begin
              err_q <= 1'b1;
            end
`endif
          end
        end

        DONE: begin
          // A still-asserted request level must be released before re-arming.
          if (!Read && !Write) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MDR_q     = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign Ready     = ready_q;
  assign Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// ============================================================================
// tb_mem_interface: vector table, corner sequences and random traffic vs model
// Rev 1.0
// ============================================================================
module tb_mem_interface;

  localparam int AW     = 9;
  localparam int TO_CYC = 16;
  localparam int OP_RD   = 0;
  localparam int OP_WR   = 1;
  localparam int OP_BOTH = 2;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic [31:0]   BusMuxOut;
  logic          MARin, MDRin, Read, Write;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic [31:0]   MDR_q;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_rd, mem_wr, Ready, Busy, MemErr;

  mem_interface #(.ADDR_W(AW), .TIMEOUT_CYC(TO_CYC)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .MDR_q     (MDR_q),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .Ready     (Ready),
    .Busy      (Busy),
    .MemErr    (MemErr)
  );

  always #5 Clock = ~Clock;

  int n_cmp  = 0;
  int n_fail = 0;

  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int rdy_cnt  = 0;
  int busy_cnt = 0;
  int both_cnt = 0;

  always @(negedge Clock) begin
    if (mem_rd) rd_cnt++;
    if (mem_wr) wr_cnt++;
    if (Ready) rdy_cnt++;
    if (Busy) busy_cnt++;
    if (mem_rd && mem_wr) both_cnt++;
  end

  logic [31:0]   ram   [1<<AW];
  logic [31:0]   m_ram [1<<AW];
  logic [AW-1:0] m_mar;
  logic [31:0]   m_mdr;

  typedef struct {
    int          op;
    bit          ld_mar;
    logic [8:0]  addr;
    bit          ld_mdr;
    bit          pre;
    logic [31:0] data;
    int          delay;
    int          hold;
    logic [31:0] exp_mdr;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one complete access, playing the RAM with a fixed ack delay.
  task automatic do_access(input int op, input bit ld_mar, input logic [AW-1:0] addr,
                           input bit ld_mdr, input logic [31:0] wdata, input int delay,
                           input int hold, input logic [AW-1:0] exp_addr,
                           input logic [31:0] exp_mdr, input int exp_rd, input int exp_wr,
                           input string tag);
    int rd0, wr0, rdy0, busy0;
    if (ld_mar) begin
      BusMuxOut = {{(32-AW){1'b0}}, addr};
      MARin = 1'b1;
      @(negedge Clock);
      MARin = 1'b0;
    end
    if (ld_mdr) begin
      BusMuxOut = wdata;
      MDRin = 1'b1;
      @(negedge Clock);
      MDRin = 1'b0;
    end
    rd0 = rd_cnt; wr0 = wr_cnt; rdy0 = rdy_cnt; busy0 = busy_cnt;
    Read  = (op != OP_WR);
    Write = (op != OP_RD);
    for (int k = 1; k <= delay; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        check({tag, " addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, " busy"}, 32'(Busy), 32'd1);
        if (op == OP_WR) check({tag, " wdata"}, mem_wdata, exp_mdr);
      end
      if (k == delay) begin
        mem_ack = 1'b1;
        if (mem_rd) mem_rdata = ram[mem_addr];
        if (mem_wr) ram[mem_addr] = mem_wdata;
      end
    end
    @(negedge Clock);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    check({tag, " ready"}, 32'(Ready), 32'd1);
    check({tag, " mdr"}, MDR_q, exp_mdr);
    check({tag, " busy_off"}, 32'(Busy), 32'd0);
    repeat (hold) @(negedge Clock);
    Read  = 1'b0;
    Write = 1'b0;
    @(negedge Clock);
    check({tag, " ready_off"}, 32'(Ready), 32'd0);
    check({tag, " rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, " wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({tag, " ready_pulses"}, 32'(rdy_cnt - rdy0), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cnt - busy0), 32'(delay));
  endtask

  initial begin
    int rdy0, rd0;
    tbl[0] = '{OP_RD,   1'b1, 9'h05A, 1'b0, 1'b1, 32'hDEADBEEF, 3, 0,  32'hDEADBEEF, 3, 0};
    tbl[1] = '{OP_WR,   1'b1, 9'h1FF, 1'b1, 1'b0, 32'h12345678, 1, 0,  32'h12345678, 0, 1};
    tbl[2] = '{OP_RD,   1'b1, 9'h000, 1'b0, 1'b1, 32'h0F0F0F0F, 1, 10, 32'h0F0F0F0F, 1, 0};
    tbl[3] = '{OP_BOTH, 1'b1, 9'h033, 1'b0, 1'b1, 32'hA5A5A5A5, 2, 0,  32'hA5A5A5A5, 2, 0};
    tbl[4] = '{OP_WR,   1'b0, 9'h033, 1'b1, 1'b0, 32'hFFFFFFFF, 4, 2,  32'hFFFFFFFF, 0, 4};
    tbl[5] = '{OP_RD,   1'b1, 9'h1FF, 1'b0, 1'b0, 32'h00000000, 2, 0,  32'h12345678, 2, 0};
    tbl[6] = '{OP_RD,   1'b0, 9'h1FF, 1'b1, 1'b0, 32'h11112222, 1, 3,  32'h12345678, 1, 0};

    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;

    Reset_n = 1'b0; BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0;
    Read = 1'b0; Write = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst mem_rd", 32'(mem_rd), 32'd0);
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst ready", 32'(Ready), 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst memerr", 32'(MemErr), 32'd0);
    check("rst mdr", MDR_q, 32'd0);
    check("rst mar", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].pre) ram[tbl[i].addr] = tbl[i].data;
      do_access(tbl[i].op, tbl[i].ld_mar, tbl[i].addr, tbl[i].ld_mdr, tbl[i].data,
                tbl[i].delay, tbl[i].hold, tbl[i].addr, tbl[i].exp_mdr,
                tbl[i].exp_rd, tbl[i].exp_wr, $sformatf("vec%0d", i));
    end

    // MARin and MDRin share a cycle; stray ack in IDLE; loads frozen during a read
    BusMuxOut = 32'h0000_0123; MARin = 1'b1; MDRin = 1'b1;
    @(negedge Clock);
    MARin = 1'b0; MDRin = 1'b0;
    check("dual load mar", 32'(mem_addr), 32'h123);
    check("dual load mdr", mem_wdata, 32'h123);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge Clock);
    mem_ack = 1'b0;
    check("idle ack mdr", MDR_q, 32'h123);
    check("idle ack ready", 32'(Ready), 32'd0);
    check("idle ack busy", 32'(Busy), 32'd0);
    ram[9'h123] = 32'h600DF00D;
    BusMuxOut = 32'h7777_7777; MDRin = 1'b1; Read = 1'b1;
    @(negedge Clock);
    check("mdrin with read", MDR_q, 32'h123);
    BusMuxOut = 32'h0000_01E0; MARin = 1'b1;
    @(negedge Clock);
    check("marin in req", 32'(mem_addr), 32'h123);
    check("mdrin in req", MDR_q, 32'h123);
    MARin = 1'b0; MDRin = 1'b0;
    mem_ack = 1'b1; mem_rdata = ram[mem_addr];
    @(negedge Clock);
    mem_ack = 1'b0;
    check("frozen read ready", 32'(Ready), 32'd1);
    check("frozen read mdr", MDR_q, 32'h600DF00D);
    Read = 1'b0;
    @(negedge Clock);
    check("frozen read ready_off", 32'(Ready), 32'd0);

    // Reset in the middle of a read abandons it
    BusMuxOut = 32'hCAFEF00D; MDRin = 1'b1;
    @(negedge Clock);
    MDRin = 1'b0; BusMuxOut = 32'h0000_00AB; MARin = 1'b1;
    @(negedge Clock);
    MARin = 1'b0; Read = 1'b1;
    rdy0 = rdy_cnt;
    repeat (5) @(negedge Clock);
`ifndef MEM_TIMEOUT_EN
    repeat (35) @(negedge Clock);
    check("no timeout memerr", 32'(MemErr), 32'd0);
`endif
    check("pre-reset mem_rd", 32'(mem_rd), 32'd1);
    check("pre-reset busy", 32'(Busy), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("async rst mem_rd", 32'(mem_rd), 32'd0);
    check("async rst busy", 32'(Busy), 32'd0);
    check("async rst mdr", MDR_q, 32'd0);
    check("async rst mar", 32'(mem_addr), 32'd0);
    Read = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clock);
    check("abandoned ready", 32'(rdy_cnt - rdy0), 32'd0);

    // Random traffic against a memory/register model
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = $urandom;
      m_ram[i] = ram[i];
    end
    m_mar = '0;
    m_mdr = '0;
    for (int i = 0; i < 50; i++) begin
      int            op, dly, hld;
      bit            lm, ld;
      logic [AW-1:0] a, ea;
      logic [31:0]   d, em;
      op  = $urandom_range(0, 2);
      lm  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 1) != 0);
      a   = AW'($urandom);
      d   = $urandom;
      dly = $urandom_range(1, 4);
      hld = $urandom_range(0, 3);
      ea  = lm ? a : m_mar;
      em  = ld ? d : m_mdr;
      if (op == OP_WR) m_ram[ea] = em;
      else em = m_ram[ea];
      m_mar = ea;
      m_mdr = em;
      do_access(op, lm, a, ld, d, dly, hld, ea, em,
                (op == OP_WR) ? 0 : dly, (op == OP_WR) ? dly : 0,
                $sformatf("rnd%0d", i));
    end

`ifdef MEM_TIMEOUT_EN
    BusMuxOut = 32'h0000_0044; MARin = 1'b1;
    @(negedge Clock);
    MARin = 1'b0;
    rd0 = rd_cnt; rdy0 = rdy_cnt;
    Read = 1'b1;
    repeat (TO_CYC) @(negedge Clock);
    check("timeout still busy", 32'(Busy), 32'd1);
    @(negedge Clock);
    check("timeout ready", 32'(Ready), 32'd1);
    check("timeout memerr", 32'(MemErr), 32'd1);
    check("timeout mdr", MDR_q, m_mdr);
    check("timeout rd_cycles", 32'(rd_cnt - rd0), 32'(TO_CYC));
    Read = 1'b0;
    @(negedge Clock);
    check("memerr sticky", 32'(MemErr), 32'd1);
    ram[9'h044] = 32'h13579BDF;
    do_access(OP_RD, 1'b0, 9'h044, 1'b0, 32'd0, 2, 0, 9'h044, 32'h13579BDF, 2, 0, "post-timeout");
    check("memerr cleared", 32'(MemErr), 32'd0);
`endif

    check("rd/wr overlap cycles", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Clock, reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameters, one per line: name, default, meaning:
- ADDR_W, 9, word-address width.
- TIMEOUT_CYC, 16, cycles to wait for mem_ack before abort (used only with MEM_TIMEOUT_EN).
REQ-003 Ports, one per line: name, direction, width, meaning:
- Clock, in, 1, system clock, rising edge.
- Reset_n, in, 1, async active-low reset.
- BusMuxOut, in, 32, internal bus value.
- MARin, in, 1, load MAR from bus.
- MDRin, in, 1, load MDR from bus (ignored while Read=1).
- Read, in, 1, control-unit read request level.
- Write, in, 1, control-unit write request level.
- mem_rdata, in, 32, RAM read data.
- mem_ack, in, 1, RAM completion strobe.
- MDR_q, out, 32, MDR contents to bus mux.
- mem_addr, out, ADDR_W, equals MAR.
- mem_wdata, out, 32, equals MDR.
- mem_rd, out, 1, RAM read strobe.
- mem_wr, out, 1, RAM write strobe.
- Ready, out, 1, one-cycle completion pulse.
- Busy, out, 1, high in RD_REQ or WR_REQ.
- MemErr, out, 1, sticky timeout flag (tied 0 without macro).

Function
REQ-004 FSM states: IDLE, RD_REQ, WR_REQ, DONE.
REQ-005 IDLE: Read=1 -> RD_REQ. Else Write=1 -> WR_REQ. Read wins if both are high; that Write is dropped.
REQ-006 RD_REQ: mem_rd=1. On mem_ack, MDR <= mem_rdata on the same edge, then -> DONE.
REQ-007 WR_REQ: mem_wr=1. On mem_ack -> DONE; MDR is unchanged.
REQ-008 mem_rd and mem_wr are never high together, and are low outside their request states.
REQ-009 DONE: Ready=1 for exactly one cycle. Then -> IDLE only when Read=0 and Write=0; otherwise hold in DONE with Ready=0. A held level must never retrigger an access.
REQ-010 Minimum latency: request seen in IDLE at edge N, ack sampled at edge N+1, Ready high during cycle N+2.
REQ-011 MARin: in IDLE/DONE, MAR <= BusMuxOut[ADDR_W-1:0]. In RD_REQ/WR_REQ it is ignored, keeping the address stable.
REQ-012 MDRin with Read=0: in IDLE/DONE, MDR <= BusMuxOut. It is ignored in RD_REQ/WR_REQ.
REQ-013 MARin and MDRin in the same cycle both load.
REQ-014 mem_ack outside RD_REQ/WR_REQ is ignored.
REQ-015 Busy = (state is RD_REQ or WR_REQ).

Reset
REQ-016 On Reset_n=0, immediately and independent of Clock:
- state=IDLE; MAR=0; MDR=0.
- mem_rd=0; mem_wr=0; Ready=0; Busy=0; MemErr=0.
REQ-017 Reset during RD_REQ/WR_REQ abandons the access: no Ready, MDR cleared.

Configuration
REQ-018 Macro MEM_TIMEOUT_EN defined:
- A counter runs in RD_REQ/WR_REQ.
- At TIMEOUT_CYC cycles without mem_ack: -> DONE, MemErr=1, MDR unchanged, Ready pulses.
- MemErr clears on the next accepted request.
REQ-019 Macro undefined: no counter exists, requests wait indefinitely, MemErr is constant 0.

Structure
REQ-020 Shared package cpu_pkg holds the mem-state enum, ADDR_W default and TIMEOUT_CYC default.
REQ-021 Optional sub-module mem_watchdog holds the timeout counter; it is instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-022 Read path: MAR=0x05A, RAM[0x05A]=0xDEADBEEF, Read=1, ack after 3 cycles -> MDR_q=0xDEADBEEF; one Ready pulse; mem_rd high exactly 3 cycles.
REQ-023 Write path: MDRin with bus=0x12345678, MARin with bus=0x1FF, Write=1 -> mem_wr with mem_addr=0x1FF and mem_wdata=0x12345678; RAM updated.
REQ-024 Held Read for 10 cycles after Ready -> exactly one mem_rd burst; FSM stays in DONE until Read=0.
REQ-025 Read=Write=1 in IDLE -> read only; mem_wr never asserts.
REQ-026 Reset_n low mid-RD_REQ -> mem_rd, Busy, MDR_q go to 0 without a clock edge; no Ready.
REQ-027 With MEM_TIMEOUT_EN, no ack -> after 16 cycles MemErr=1, Ready pulses, MDR unchanged; the next successful read clears MemErr.
